calc_bus_sequencer: RTL

- Front-end controller for the SingleCycleuProcessor calculator port (EntradaCalcu / addressCalcu / writeEnableCalcu / resultadoCalcu).
- Accepts one command (operand A, operand B, opcode) over a valid/ready handshake.
- Writes A, B and the opcode to the processor's mailbox words in a fixed order, waits a fixed compute window, then samples the result.
- Returns the result over a valid/ready response channel. It is the only master of the calculator port.

---
 rtl/calc_seq_pkg.sv | 37 +++
 rtl/calc_seq_timer.sv | 27 ++
 rtl/calc_bus_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator-port bus sequencer.
package calc_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    GAP_A,
    WR_B,
    GAP_B,
    WR_OP,
    GAP_OP,
    WAIT,
    RESP,
    CLR_WR,
    CLR_GAP
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4
  } calc_op_t;

  localparam logic [31:0] DEF_ADDR_OP = 32'd0;
  localparam logic [31:0] DEF_ADDR_A  = 32'd16;
  localparam logic [31:0] DEF_ADDR_B  = 32'd20;

  // Wide enough for the longest timed state (compute window up to 4095).
  localparam int CNT_W = 12;

  function automatic logic op_legal(input logic [3:0] op, input int unsigned num_ops);
    return (op != OP_NONE) && (32'(op) <= num_ops);
  endfunction

endpackage

// File: rtl/calc_seq_timer.sv
// Loadable down-counter shared by every timed state; done flags the final cycle.
module calc_seq_timer
  import calc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Parks at 1 instead of wrapping; the owner reloads on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count > CNT_W'(1)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/calc_bus_sequencer.sv
// Drives one calculator command onto the processor mailbox port (A, B, opcode),
// waits the compute window, then returns the sampled result.
module calc_bus_sequencer
  import calc_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_A         = DEF_ADDR_A,
  parameter logic [31:0] ADDR_B         = DEF_ADDR_B,
  parameter logic [31:0] ADDR_OP        = DEF_ADDR_OP,
  parameter int unsigned HOLD_CYCLES    = 10,
  parameter int unsigned GAP_CYCLES     = 10,
  parameter int unsigned COMPUTE_CYCLES = 64,
  parameter int unsigned NUM_OPS        = 32'(OP_DIV),
  parameter bit          CLEAR_OP       = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] EntradaCalcu,
  output logic [31:0] addressCalcu,
  output logic        writeEnableCalcu,
  input  logic [31:0] resultadoCalcu,
  output seq_state_t  state
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] COMP_LD = CNT_W'(COMPUTE_CYCLES);

  logic [31:0]      b_q;
  logic [3:0]       op_q;
  logic             accept;
  logic             cmd_legal;
  logic             rsp_hs;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; rsp_valid never drops without a transfer, cmd_ready only in IDLE.
  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign cmd_legal = op_legal(cmd_op, NUM_OPS);
  assign rsp_hs    = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    load     = 1'b0;
    load_val = HOLD_LD;
    unique case (state)
      IDLE:                       load = accept && cmd_legal;
      WR_A, WR_B, WR_OP, CLR_WR: begin
        load     = done;
        load_val = GAP_LD;
      end
      GAP_A, GAP_B:               load = done;
      GAP_OP: begin
        load     = done;
        load_val = COMP_LD;
      end
      RESP:                       load = rsp_hs && CLEAR_OP && !rsp_err;
      default:                    load = 1'b0;
    endcase
  end

  calc_seq_timer u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_err          <= 1'b0;
      EntradaCalcu     <= '0;
      addressCalcu     <= '0;
      writeEnableCalcu <= 1'b1;
      b_q              <= '0;
      op_q             <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            b_q       <= cmd_b;
            op_q      <= cmd_op;
            if (cmd_legal) begin
              state            <= WR_A;
              addressCalcu     <= ADDR_A;
              EntradaCalcu     <= cmd_a;
              writeEnableCalcu <= 1'b0;
            end else begin
              // Rejected opcode: answer at once, the bus is never touched.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        WR_A: if (done) begin
          state            <= GAP_A;
          writeEnableCalcu <= 1'b1;
        end
        GAP_A: if (done) begin
          state            <= WR_B;
          addressCalcu     <= ADDR_B;
          EntradaCalcu     <= b_q;
          writeEnableCalcu <= 1'b0;
        end
        WR_B: if (done) begin
          state            <= GAP_B;
          writeEnableCalcu <= 1'b1;
        end
        GAP_B: if (done) begin
          state            <= WR_OP;
          addressCalcu     <= ADDR_OP;
          EntradaCalcu     <= 32'(op_q);
          writeEnableCalcu <= 1'b0;
        end
        WR_OP: if (done) begin
          state            <= GAP_OP;
          writeEnableCalcu <= 1'b1;
        end
        GAP_OP: if (done) begin
          state <= WAIT;
        end
        WAIT: if (done) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= resultadoCalcu;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (CLEAR_OP && !rsp_err) begin
            state            <= CLR_WR;
            addressCalcu     <= ADDR_OP;
            EntradaCalcu     <= '0;
            writeEnableCalcu <= 1'b0;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        CLR_WR: if (done) begin
          state            <= CLR_GAP;
          writeEnableCalcu <= 1'b1;
        end
        CLR_GAP: if (done) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
